// File: rtl/axis_seq_checker_pkg.sv
// Shared types and constants for the AXI4-Stream sequence checker.
// Optional feature macro: AXIS_SEQ_CHECKER_THROTTLE_EN (LFSR throttling of tready).
package axis_seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    localparam int          ERR_CNT_W = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // tdest is at least one bit wide even for a single channel
    function automatic int tdest_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11) used to throttle tready.
// Only instantiated when AXIS_SEQ_CHECKER_THROTTLE_EN is defined.
module axis_chk_lfsr
    import axis_seq_checker_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic load,
    input  logic en,
    output logic bit_out
);

    logic [15:0] lfsr_q;

    // reseed on a new run so every run sees the same throttle pattern
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q <= LFSR_SEED;
        end else if (load) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/axis_seq_checker.sv
// AXI4-Stream sink checking a per-channel incrementing counter pattern,
// tlast placement at burst boundaries, with word/error counters, first-error
// capture and an idle watchdog.
// Optional feature macro: AXIS_SEQ_CHECKER_THROTTLE_EN adds throttle_en.
module axis_seq_checker
    import axis_seq_checker_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_CH         = 2,
    parameter  int BURSTLENGTH    = 16,
    parameter  int TIMEOUT_CYCLES = 128,
    parameter  int CNT_WIDTH      = 32,
    localparam int TDEST_W        = tdest_w(NUM_CH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
    input  logic                  throttle_en,
`endif
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  depth,
    input  logic [DATA_WIDTH-1:0] seq_init,
    input  logic                  check_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [TDEST_W-1:0]    s_axis_tdest,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [ERR_CNT_W-1:0]  data_err_cnt,
    output logic [ERR_CNT_W-1:0]  tlast_err_cnt,
    output logic                  first_err_valid,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [DATA_WIDTH-1:0] first_err_expected
);

    localparam int BL_W = (BURSTLENGTH > 1) ? $clog2(BURSTLENGTH) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BL_W-1:0] BEAT_LAST = BL_W'(BURSTLENGTH - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                             state;
    logic                               run_ready;
    logic [CNT_WIDTH-1:0]               depth_q;
    logic                               chk_tlast_q;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]  exp_q;
    logic [NUM_CH-1:0][BL_W-1:0]        beat_q;
    logic [WD_W-1:0]                    wd_q;

    logic                  accept;
    logic                  ch_ok;
    logic [TDEST_W-1:0]    sel;
    logic [DATA_WIDTH-1:0] cur_exp;
    logic                  last_exp;
    logic                  data_bad;
    logic                  tlast_bad;
    logic [CNT_WIDTH-1:0]  word_nxt;

`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
    logic lfsr_bit;

    axis_chk_lfsr u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (start && (state != RUN)),
        .en      (state == RUN),
        .bit_out (lfsr_bit)
    );

    assign s_axis_tready = run_ready && !(throttle_en && lfsr_bit);
`else
    assign s_axis_tready = run_ready;
`endif

    // per-beat decode: channel select, expected value and pass/fail flags
    always_comb begin
        accept    = s_axis_tvalid && s_axis_tready;
        ch_ok     = int'(s_axis_tdest) < NUM_CH;
        sel       = ch_ok ? s_axis_tdest : '0;
        cur_exp   = exp_q[sel];
        last_exp  = (beat_q[sel] == BEAT_LAST);
        data_bad  = !ch_ok || (s_axis_tdata != cur_exp);
        tlast_bad = chk_tlast_q && ch_ok && (s_axis_tlast != last_exp);
        word_nxt  = word_cnt + CNT_WIDTH'(1);
    end

    // run control FSM with registered outputs, counters and per-channel state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            run_ready          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout            <= 1'b0;
            depth_q            <= '0;
            chk_tlast_q        <= 1'b0;
            exp_q              <= '0;
            beat_q             <= '0;
            wd_q               <= '0;
            word_cnt           <= '0;
            data_err_cnt       <= '0;
            tlast_err_cnt      <= '0;
            first_err_valid    <= 1'b0;
            first_err_data     <= '0;
            first_err_expected <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        word_cnt <= word_nxt;
                        wd_q     <= '0;
                        // resync to the received value so one bad beat is one error
                        if (ch_ok) begin
                            exp_q[sel]  <= s_axis_tdata + DATA_WIDTH'(1);
                            beat_q[sel] <= (last_exp || s_axis_tlast) ? '0
                                                                      : beat_q[sel] + BL_W'(1);
                        end
                        if (data_bad) begin
                            if (data_err_cnt != '1)
                                data_err_cnt <= data_err_cnt + ERR_CNT_W'(1);
                            if (!first_err_valid) begin
                                first_err_valid    <= 1'b1;
                                first_err_data     <= s_axis_tdata;
                                first_err_expected <= ch_ok ? cur_exp : '0;
                            end
                        end
                        if (tlast_bad && (tlast_err_cnt != '1))
                            tlast_err_cnt <= tlast_err_cnt + ERR_CNT_W'(1);
                        // drop ready on the same edge as the final beat
                        if (word_nxt == depth_q) begin
                            state     <= DONE;
                            run_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            run_ready <= 1'b1;
                        end
                    end else if (wd_q == WD_LAST) begin
                        state     <= TOUT;
                        run_ready <= 1'b0;
                        busy      <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        wd_q      <= wd_q + WD_W'(1);
                        run_ready <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        depth_q            <= depth;
                        chk_tlast_q        <= check_tlast;
                        for (int c = 0; c < NUM_CH; c++) begin
                            exp_q[c]  <= seq_init;
                            beat_q[c] <= '0;
                        end
                        wd_q               <= '0;
                        word_cnt           <= '0;
                        data_err_cnt       <= '0;
                        tlast_err_cnt      <= '0;
                        first_err_valid    <= 1'b0;
                        first_err_data     <= '0;
                        first_err_expected <= '0;
                        timeout            <= 1'b0;
                        run_ready          <= 1'b0;
                        if (depth == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
Synthesizable AXI4-Stream sink on the master (mm2s) side of the DDR virtual FIFO. It consumes a fixed number of beats and checks them against an incrementing per-channel counter pattern. It also checks tlast placement at burst boundaries and reports word/error counts, first-error capture and a read timeout. It is the in-fabric reader matching the counter-pattern writer used for VFIFO loopback runs.

Parameters:
DATA_WIDTH, 32, tdata width
NUM_CH, 2, number of tdest channels (tdest width = max(1, clog2(NUM_CH)))
BURSTLENGTH, 16, beats per packet; tlast expected on beat BURSTLENGTH-1 of each channel packet
TIMEOUT_CYCLES, 128, consecutive cycles without an accepted beat before abort
CNT_WIDTH, 32, width of word counters and depth input

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run (accepted only in IDLE)
depth  in  CNT_WIDTH  beats to consume in this run; sampled on start
seq_init  in  DATA_WIDTH  expected first value, loaded into all channels on start
check_tlast  in  1  enable tlast checking; sampled on start
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tlast  in  1  stream last
s_axis_tdest  in  TDEST_W  stream channel
busy  out  1  run in progress
done  out  1  run completed with word_cnt==depth; held until next start
timeout  out  1  run aborted by watchdog; held until next start
word_cnt  out  CNT_WIDTH  beats accepted this run
data_err_cnt  out  16  data mismatches, saturating at 16'hFFFF
tlast_err_cnt  out  16  tlast mismatches, saturating
first_err_valid  out  1  a data mismatch has been captured
first_err_data  out  DATA_WIDTH  received value of first mismatch
first_err_expected  out  DATA_WIDTH  expected value of first mismatch

Behaviour:
- Reset: state IDLE. All outputs 0: s_axis_tready, busy, done, timeout, counters, first_err_*. Per-channel expected and beat counters 0.
- States: IDLE, RUN, DONE, TOUT.
- IDLE: tready=0. On start: latch depth/check_tlast; expected[c]=seq_init and pkt_beat[c]=0 for all c; clear counters, first_err, done, timeout. depth==0 goes directly to DONE; otherwise goes to RUN.
- RUN: busy=1. tready is registered and asserts the cycle after entering RUN. A beat is accepted when tvalid && tready.
- Accept on channel c: compare tdata to expected[c]. Mismatch: data_err_cnt++ (saturating); if !first_err_valid, capture tdata/expected and set first_err_valid. In both cases expected[c] <= tdata+1 (resync, modulo 2^DATA_WIDTH, so wrap FFFFFFFF->0 is legal).
- tlast check (if latched check_tlast): expected_last = (pkt_beat[c]==BURSTLENGTH-1). If tlast != expected_last, tlast_err_cnt++. pkt_beat[c] wraps to 0 on BURSTLENGTH-1 or on a received tlast, whichever comes first.
- tdest >= NUM_CH: beat is accepted and counted as a data error. expected_* is left unchanged; first_err_expected=0.
- word_cnt increments per accepted beat. On the beat making word_cnt==depth: tready drops combinationally the next cycle (registered to 0 in the same edge) and state moves to DONE. No beat beyond depth is ever accepted.
- Watchdog counter: cleared on every accepted beat, incremented otherwise. At TIMEOUT_CYCLES-1 the state goes to TOUT and tready goes to 0. An accept in the same cycle as expiry wins, and the counter is cleared.
- DONE/TOUT: busy=0, tready=0, flag set. Next start restarts as from IDLE.
- start while RUN: ignored.
- aresetn low at any time, including mid-burst: immediate return to reset values. Upstream sees tready drop asynchronously.

Optional Feature:
Macro AXIS_SEQ_CHECKER_THROTTLE_EN.
- Defined: adds input throttle_en (1 bit). A 16-bit maximal-length LFSR (seed 16'hACE1, advances every cycle in RUN) gates tready: tready = run_ready && !(throttle_en && lfsr[0]). Throttled cycles still advance the watchdog.
- Undefined: port absent; tready is a pure function of state.

Decomposition:
- Package axis_seq_checker_pkg: state enum (IDLE, RUN, DONE, TOUT), ERR_CNT_W=16, LFSR_SEED, tdest width function.
- Sub-module axis_chk_lfsr: 16-bit Fibonacci LFSR with enable; instantiated only under the macro.

Test Plan:
- seq_init=0, depth=32, check_tlast=1, 32 contiguous beats 0..31 on tdest 0, tlast on beats 15/31 -> done=1, word_cnt=32, both err counts 0, tready low after beat 31.
- Same run, beat 10 carries 0x55 -> data_err_cnt=1, first_err_data=0x55, first_err_expected=10; beat 11 value 0x56 accepted without a further error.
- Interleaved tdest 0/1, each channel counting 0..15 independently, tlast missing on channel 1 beat 15 -> tlast_err_cnt=1, data_err_cnt=0.
- depth=8, only 5 beats sent then tvalid=0 -> timeout=1 after TIMEOUT_CYCLES idle cycles, word_cnt=5, done=0.
- seq_init=32'hFFFFFFFE, depth=4, beats FFFFFFFE, FFFFFFFF, 0, 1 -> done, 0 errors; aresetn pulsed low mid-run in a rerun -> all outputs 0 immediately.
- Macro defined, throttle_en=1, depth=64 -> tready toggles per LFSR, every beat accepted exactly once, done with 0 errors.
